// File: rtl/text_frame_serializer_pkg.sv
// Shared definitions for the text frame serializer: FSM state encoding,
// block/character geometry, the default preamble and a character-select helper.
package text_frame_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SYNC   = 2'b01,
        DATA   = 2'b10,
        PARITY = 2'b11
    } state_t;

    localparam int FRAME_CHARS = 64;
    localparam int CHAR_BITS   = 8;
    localparam int BLOCK_BITS  = FRAME_CHARS * CHAR_BITS;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h7E;

    // char0 sits in the top byte of the block, char63 in the bottom byte.
    function automatic logic [CHAR_BITS-1:0] get_char(input logic [BLOCK_BITS-1:0] block,
                                                      input logic [5:0] idx);
        return block[(BLOCK_BITS - CHAR_BITS) - CHAR_BITS * int'(idx) +: CHAR_BITS];
    endfunction

endpackage

// File: rtl/text_frame_serializer_char_parity_shift.sv
// Per-character shifter. The MSB of a character is sent straight from the
// load value by the parent, so only the remaining 7 bits are held here and
// presented MSB-first; even parity of the full character is latched on load.
module char_parity_shift
    import text_frame_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CHAR_BITS-1:0] load_char,
    input  logic                 shift,
    output logic                 next_bit,
    output logic                 parity
);

    logic [CHAR_BITS-2:0] rest_bits;
    logic                 parity_reg;

    // Load a new character (keeping its lower bits and parity) or shift one bit out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rest_bits  <= '0;
            parity_reg <= 1'b0;
        end else if (load) begin
            rest_bits  <= load_char[CHAR_BITS-2:0];
            parity_reg <= ^load_char;
        end else if (shift) begin
            rest_bits  <= {rest_bits[CHAR_BITS-3:0], 1'b0};
        end
    end

    assign next_bit = rest_bits[CHAR_BITS-2];
    assign parity   = parity_reg;

endmodule

// File: rtl/text_frame_serializer.sv
// Text frame serializer: captures a 64-character block and sends it as a
// serial frame (sync word, then each character MSB-first with optional even
// parity) under a valid/ready handshake. All outputs are registered.
module text_frame_serializer
    import text_frame_serializer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter logic       PARITY_EN = 1'b1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  block_valid,
    input  logic [BLOCK_BITS-1:0] block_in,
    output logic                  block_ack,
    input  logic                  bit_ready,
    output logic                  bit_valid,
    output logic                  bit_out,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  busy
);

    state_t                state;
    logic [BLOCK_BITS-1:0] hold_reg;
    logic [5:0]            char_idx;
    logic [2:0]            bit_idx;

    logic                  transfer;
    logic                  last_char;
    logic                  char_done;
    logic [5:0]            next_char_idx;
    logic [CHAR_BITS-1:0]  next_char;
    logic                  sh_load;
    logic                  sh_shift;
    logic                  sh_next_bit;
    logic                  sh_parity;

    // Handshake decode and selection of the character that is loaded next.
    always_comb begin
        transfer      = bit_valid & bit_ready;
        last_char     = (char_idx == 6'd63);
        next_char_idx = (state == SYNC) ? 6'd0 : char_idx + 6'd1;
        next_char     = get_char(hold_reg, next_char_idx);
        char_done     = transfer &&
                        (((state == DATA) && (bit_idx == 3'd0) && !PARITY_EN) ||
                         (state == PARITY));
        sh_load       = (transfer && (state == SYNC) && (bit_idx == 3'd0)) ||
                        (char_done && !last_char);
        sh_shift      = transfer && (state == DATA) && (bit_idx != 3'd0);
    end

    // Holding register is only written on capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && block_valid) begin
            hold_reg <= block_in;
        end
    end

    char_parity_shift u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_char (next_char),
        .shift     (sh_shift),
        .next_bit  (sh_next_bit),
        .parity    (sh_parity)
    );

    // Frame FSM; every output is computed one edge ahead so it is stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            char_idx    <= 6'd0;
            bit_idx     <= 3'd0;
            block_ack   <= 1'b0;
            bit_valid   <= 1'b0;
            bit_out     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            block_ack <= 1'b0;
            case (state)
                IDLE: begin
                    bit_valid   <= 1'b0;
                    bit_out     <= 1'b0;
                    frame_start <= 1'b0;
                    frame_end   <= 1'b0;
                    busy        <= 1'b0;
                    if (block_valid) begin
                        state       <= SYNC;
                        block_ack   <= 1'b1;
                        char_idx    <= 6'd0;
                        bit_idx     <= 3'd7;
                        bit_valid   <= 1'b1;
                        bit_out     <= SYNC_WORD[7];
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SYNC: begin
                    if (transfer) begin
                        frame_start <= 1'b0;
                        if (bit_idx == 3'd0) begin
                            state    <= DATA;
                            char_idx <= 6'd0;
                            bit_idx  <= 3'd7;
                            bit_out  <= next_char[CHAR_BITS-1];
                        end else begin
                            bit_idx  <= bit_idx - 3'd1;
                            bit_out  <= SYNC_WORD[bit_idx - 3'd1];
                        end
                    end
                end
                DATA: begin
                    if (transfer) begin
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            bit_out <= sh_next_bit;
                            if (last_char && (bit_idx == 3'd1) && !PARITY_EN) begin
                                frame_end <= 1'b1;
                            end
                        end else if (PARITY_EN) begin
                            state   <= PARITY;
                            bit_out <= sh_parity;
                            if (last_char) begin
                                frame_end <= 1'b1;
                            end
                        end
                    end
                end
                PARITY: begin
                    // Advance is handled below, shared with the no-parity path.
                end
                default: begin
                    state       <= IDLE;
                    char_idx    <= 6'd0;
                    bit_idx     <= 3'd0;
                    bit_valid   <= 1'b0;
                    bit_out     <= 1'b0;
                    frame_start <= 1'b0;
                    frame_end   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase

            if (char_done) begin
                if (last_char) begin
                    state     <= IDLE;
                    char_idx  <= 6'd0;
                    bit_idx   <= 3'd0;
                    bit_valid <= 1'b0;
                    bit_out   <= 1'b0;
                    frame_end <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    state    <= DATA;
                    char_idx <= char_idx + 6'd1;
                    bit_idx  <= 3'd7;
                    bit_out  <= next_char[CHAR_BITS-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_text_frame_serializer.sv
// Testbench for text_frame_serializer: table-driven frames compared against a
// small frame model, plus hand-written hold, reset-abort and no-parity sequences.
module tb_text_frame_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         block_valid;
    logic [511:0] block_in;
    logic         block_ack;
    logic         bit_ready;
    logic         bit_valid;
    logic         bit_out;
    logic         frame_start;
    logic         frame_end;
    logic         busy;

    logic         np_block_valid;
    logic [511:0] np_block_in;
    logic         np_block_ack;
    logic         np_bit_ready;
    logic         np_bit_valid;
    logic         np_bit_out;
    logic         np_frame_start;
    logic         np_frame_end;
    logic         np_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic rx_bits  [0:1023];
    logic exp_bits [0:1023];

    typedef struct {
        string        name;
        logic [511:0] block;
        int           ready_mode;
        int           exp_len;
        int           exp_valid_cycles;
    } vector_t;

    vector_t vectors [5];

    always #5 clk = ~clk;

    text_frame_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .block_valid (block_valid),
        .block_in    (block_in),
        .block_ack   (block_ack),
        .bit_ready   (bit_ready),
        .bit_valid   (bit_valid),
        .bit_out     (bit_out),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    text_frame_serializer #(.SYNC_WORD(8'h7E), .PARITY_EN(1'b0)) dut_np (
        .clk         (clk),
        .reset       (reset),
        .block_valid (np_block_valid),
        .block_in    (np_block_in),
        .block_ack   (np_block_ack),
        .bit_ready   (np_bit_ready),
        .bit_valid   (np_bit_valid),
        .bit_out     (np_bit_out),
        .frame_start (np_frame_start),
        .frame_end   (np_frame_end),
        .busy        (np_busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [511:0] blk);
        block_in    = blk;
        block_valid = 1'b1;
    endtask

    function automatic int buildExpected(input logic [511:0] block, input bit parity_en);
        logic [7:0] sw;
        logic [7:0] ch;
        int n;
        sw = 8'h7E;
        n  = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = sw[7 - i];
            n = n + 1;
        end
        for (int c = 0; c < 64; c++) begin
            ch = block[511 - 8 * c -: 8];
            for (int b = 0; b < 8; b++) begin
                exp_bits[n] = ch[7 - b];
                n = n + 1;
            end
            if (parity_en) begin
                exp_bits[n] = ^ch;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic int streamMismatches(input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_bits[i] !== exp_bits[i]) errs++;
        end
        return errs;
    endfunction

    task automatic collectFrame(input int ready_mode, input bit hold, input bit scramble,
                                input int abort_at, input int max_cycles,
                                output int n_bits, output int valid_cycles, output int ack_count,
                                output int stall_err, output int start_pos, output int end_pos,
                                output int first_valid);
        int         cycles;
        bit         stalled;
        bit         done;
        logic [3:0] prev;
        logic [31:0] r;
        n_bits = 0; valid_cycles = 0; ack_count = 0; stall_err = 0;
        start_pos = 0; end_pos = 0; first_valid = 0;
        cycles = 0; stalled = 1'b0; done = 1'b0; prev = '0;
        while (!done && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (block_ack) begin
                ack_count++;
                if (!hold) block_valid = 1'b0;
            end
            if (scramble) begin
                r = $urandom();
                block_in = {16{r}};
            end
            if (stalled && ({bit_valid, bit_out, frame_start, frame_end} !== prev)) stall_err++;
            if (bit_valid) begin
                valid_cycles++;
                if (first_valid == 0) first_valid = cycles;
            end
            bit_ready = (ready_mode == 0) || (valid_cycles % 2 == 0);
            stalled   = bit_valid && !bit_ready;
            prev      = {1'b1, bit_out, frame_start, frame_end};
            if (bit_valid && bit_ready) begin
                if (n_bits < 1024) rx_bits[n_bits] = bit_out;
                if (frame_start && start_pos == 0) start_pos = n_bits + 1;
                if (frame_end && end_pos == 0) end_pos = n_bits + 1;
                n_bits++;
                if (frame_end || n_bits == abort_at) done = 1'b1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] ramp;
        logic [16:0]  head;
        logic [8:0]   c0;
        int n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid;
        int n_exp, errs, ones, np_cnt, np_end;

        for (int i = 0; i < 64; i++) ramp[511 - 8 * i -: 8] = i[7:0];

        vectors[0] = '{"all41",        {64{8'h41}},          0, 584, 584};
        vectors[1] = '{"char0_07",     {8'h07, 504'h0},      0, 584, 584};
        vectors[2] = '{"toggle41",     {64{8'h41}},          1, 584, 1168};
        vectors[3] = '{"ramp",         ramp,                 0, 584, 584};
        vectors[4] = '{"A5_toggle",    {64{8'hA5}},          1, 584, 1168};

        reset = 1'b0;
        block_valid = 1'b0; block_in = '0; bit_ready = 1'b0;
        np_block_valid = 1'b0; np_block_in = '0; np_bit_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {block_ack, bit_valid, bit_out, frame_start, frame_end, busy}, 6'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle without block_valid", {block_ack, bit_valid, busy}, 3'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i].block);
            collectFrame(vectors[i].ready_mode, 1'b0, 1'b0, 0, 2000,
                         n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid);
            n_exp = buildExpected(vectors[i].block, 1'b1);
            checkOutput({vectors[i].name, " length"}, n_bits, vectors[i].exp_len);
            checkOutput({vectors[i].name, " model length"}, n_exp, vectors[i].exp_len);
            checkOutput({vectors[i].name, " stream errors"}, streamMismatches(n_exp), 0);
            checkOutput({vectors[i].name, " frame_start pos"}, start_pos, 1);
            checkOutput({vectors[i].name, " frame_end pos"}, end_pos, vectors[i].exp_len);
            checkOutput({vectors[i].name, " ack count"}, ack_count, 1);
            checkOutput({vectors[i].name, " first valid latency"}, first_valid, 1);
            checkOutput({vectors[i].name, " stall stability errors"}, stall_err, 0);
            checkOutput({vectors[i].name, " valid cycles"}, valid_cycles, vectors[i].exp_valid_cycles);
            if (i == 0) begin
                for (int k = 0; k < 17; k++) head[16 - k] = rx_bits[k];
                checkOutput("all41 head bits", head, 17'b01111110_01000001_0);
            end
            if (i == 1) begin
                for (int k = 0; k < 9; k++) c0[8 - k] = rx_bits[8 + k];
                checkOutput("char0_07 bits 9..17", c0, 9'b00000111_1);
                errs = 0;
                for (int k = 1; k < 64; k++) if (rx_bits[8 + 9 * k + 8] !== 1'b0) errs++;
                checkOutput("char0_07 other parity bits", errs, 0);
            end
            @(negedge clk);
            checkOutput({vectors[i].name, " idle after frame"}, {busy, bit_valid, block_ack}, 3'b0);
        end

        // block_valid held through a frame while block_in keeps changing
        applyStimulus(ramp);
        collectFrame(0, 1'b1, 1'b1, 0, 2000,
                     n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid);
        n_exp = buildExpected(ramp, 1'b1);
        checkOutput("hold frame1 length", n_bits, 584);
        checkOutput("hold frame1 stream errors", streamMismatches(n_exp), 0);
        checkOutput("hold frame1 ack count", ack_count, 1);
        block_in = {64{8'h5A}};
        collectFrame(0, 1'b0, 1'b0, 0, 2000,
                     n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid);
        n_exp = buildExpected({64{8'h5A}}, 1'b1);
        checkOutput("hold frame2 first valid after idle cycle", first_valid, 2);
        checkOutput("hold frame2 length", n_bits, 584);
        checkOutput("hold frame2 stream errors", streamMismatches(n_exp), 0);
        checkOutput("hold frame2 ack count", ack_count, 1);
        @(negedge clk);

        // reset pulse in the middle of a frame
        applyStimulus({64{8'h41}});
        collectFrame(0, 1'b0, 1'b0, 100, 2000,
                     n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid);
        checkOutput("abort bits before reset", n_bits, 100);
        reset = 1'b0;
        #1;
        checkOutput("mid-frame reset outputs", {block_ack, bit_valid, bit_out, frame_start, frame_end, busy}, 6'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("after reset idle", {block_ack, bit_valid, busy}, 3'b0);
        applyStimulus(ramp);
        collectFrame(0, 1'b0, 1'b0, 0, 2000,
                     n_bits, valid_cycles, ack_count, stall_err, start_pos, end_pos, first_valid);
        n_exp = buildExpected(ramp, 1'b1);
        checkOutput("post-reset length", n_bits, 584);
        checkOutput("post-reset stream errors", streamMismatches(n_exp), 0);
        checkOutput("post-reset frame_start pos", start_pos, 1);
        checkOutput("post-reset ack count", ack_count, 1);
        @(negedge clk);

        // no-parity instance with an all-ones block
        np_block_in = {64{8'hFF}};
        np_block_valid = 1'b1;
        np_bit_ready = 1'b1;
        np_cnt = 0; np_end = 0; ones = 0;
        for (int c = 0; c < 2000 && np_end == 0; c++) begin
            @(negedge clk);
            if (np_block_ack) np_block_valid = 1'b0;
            if (np_bit_valid) begin
                if (np_cnt < 1024) rx_bits[np_cnt] = np_bit_out;
                if (np_bit_out === 1'b1) ones++;
                np_cnt++;
                if (np_frame_end) np_end = np_cnt;
            end
        end
        n_exp = buildExpected({64{8'hFF}}, 1'b0);
        checkOutput("no-parity length", np_cnt, 520);
        checkOutput("no-parity frame_end pos", np_end, 520);
        checkOutput("no-parity ones count", ones, 518);
        checkOutput("no-parity stream errors", streamMismatches(n_exp), 0);
        @(negedge clk);
        checkOutput("no-parity idle after frame", {np_busy, np_bit_valid}, 2'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/text_frame_serializer.md
TEXT_FRAME_SERIALIZER -- requirements
Module: text_frame_serializer

Interface
REQ-001 Parameter: SYNC_WORD, default 8'h7E, 8-bit preamble sent MSB-first ahead of every frame.
REQ-002 Parameter: PARITY_EN, default 1; 1 appends an even-parity bit after each character, 0 omits it.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: block_valid  input  1  a 64-character block is present on block_in.
REQ-006 Port: block_in  input  512  block {char0 ... char63}; char0 = block_in[511:504], char63 = block_in[7:0].
REQ-007 Port: block_ack  output  1  one-cycle pulse: block captured; source may present the next block.
REQ-008 Port: bit_ready  input  1  downstream (modulator) accepts bit_out this cycle.
REQ-009 Port: bit_valid  output  1  bit_out holds a valid frame bit.
REQ-010 Port: bit_out  output  1  current serial bit.
REQ-011 Port: frame_start  output  1  high while bit_valid carries the first SYNC_WORD bit.
REQ-012 Port: frame_end  output  1  high while bit_valid carries the last bit of the frame.
REQ-013 Port: busy  output  1  high from block capture until the last bit is accepted.

Function
REQ-014 States SHALL be IDLE, SYNC, DATA, PARITY; no other reachable state, and any illegal encoding SHALL return to IDLE.
REQ-015 A bit transfers only on a cycle with bit_valid=1 and bit_ready=1; bit_out, frame_start and frame_end SHALL stay stable while bit_valid=1 and bit_ready=0.
REQ-016 IDLE: bit_valid=0, busy=0; if block_valid=1, capture block_in into a 512-bit holding register, assert block_ack for exactly the following cycle, go to SYNC.
REQ-017 block_valid SHALL be ignored in every state other than IDLE; block_ack SHALL never pulse more than once per frame.
REQ-018 SYNC: bit_valid=1, send SYNC_WORD[7] down to [0]; after the 8th transfer go to DATA with char index 0, bit index 7.
REQ-019 DATA: send the current character MSB-first; after bit 0 transfers go to PARITY if PARITY_EN=1, else advance the character.
REQ-020 PARITY: send the XOR of the 8 bits of the current character; on transfer, advance the character.
REQ-021 Character advance: if char index < 63, increment it and return to DATA; if char index = 63, go to IDLE on the same edge.
REQ-022 Frame length SHALL be 8 + 64*9 = 584 bits (PARITY_EN=1) or 8 + 512 = 520 bits (PARITY_EN=0).
REQ-023 frame_end SHALL be asserted with the last bit: char63 parity bit, or char63 bit 0 when PARITY_EN=0.
REQ-024 Char index SHALL be 6 bits and bit index 3 bits; neither wraps within a frame.
REQ-025 Latency: first bit_valid appears 1 cycle after the capture edge; with bit_ready held at 1, one bit transfers per cycle, with no gap between frames beyond one IDLE cycle.
REQ-026 A block_valid held high in IDLE after frame end SHALL start a new frame; back-to-back frames SHALL each produce their own block_ack.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and set block_ack, bit_valid, bit_out, frame_start, frame_end and busy to 0, and both indices to 0.
REQ-028 Reset mid-frame SHALL abandon the frame; the holding register need not be cleared, and no block_ack is issued for the aborted frame.
REQ-029 After reset deassertion, the first capture SHALL require block_valid=1 seen in IDLE on a clock edge.

Structure
REQ-030 The shared package SHALL hold the state encoding, FRAME_CHARS=64, CHAR_BITS=8 and the default SYNC_WORD.
REQ-031 The design SHALL use one sub-module, char_parity_shift: it loads an 8-bit character, shifts it MSB-first and supplies its even parity.

Verification
REQ-032 Block of 64 x 8'h41, bit_ready=1 -> 584 bits: 01111110, then 64 x (01000001,0); block_ack is 1 cycle; frame_end is on bit 584.
REQ-033 char0=8'h07, others 8'h00 -> bits 9..17 read 00000111,1; all other parity bits read 0.
REQ-034 bit_ready toggling 1/0 each cycle -> identical 584-bit sequence; bit_out is stable on every stalled cycle; the frame takes 1168 cycles.
REQ-035 block_valid held at 1 for a whole frame with a changing block_in -> only the first value is transmitted; exactly one block_ack; a second frame starts after the IDLE cycle.
REQ-036 reset=0 pulsed at bit 100 -> all outputs are 0 in the same cycle; the next frame starts cleanly with SYNC_WORD.
REQ-037 PARITY_EN=0, block 8'hFF x 64 -> 520 bits; frame_end is on bit 520; no parity bits appear.
